// File: rtl/reg_file_pkg.sv
// Shared constants and types for the RV32I integer register file.
// Optional build macro: REG_FILE_WRITE_BYPASS_EN (write-through forwarding on reads).
package reg_file_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] reg_data_t;

  localparam reg_addr_t REG_ZERO  = {AW{1'b0}};
  localparam reg_data_t DATA_ZERO = {XLEN{1'b0}};

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port: address mux with x0 forced to zero.
// With REG_FILE_WRITE_BYPASS_EN defined, an in-flight write to the same address is forwarded.
module reg_file_rd_port
  import reg_file_pkg::*;
(
  input  logic [NREGS-1:0][XLEN-1:0] regs_i,
  input  reg_addr_t                  rs_i,
`ifdef REG_FILE_WRITE_BYPASS_EN
  input  logic                       we_i,
  input  reg_addr_t                  rd_i,
  input  reg_data_t                  wdata_i,
`endif
  output reg_data_t                  rdata_o
);

  // Select the addressed register, forwarding the write data when enabled.
  always_comb begin
    rdata_o = DATA_ZERO;
    if (rs_i == REG_ZERO) begin
      rdata_o = DATA_ZERO;
`ifdef REG_FILE_WRITE_BYPASS_EN
    end else if (we_i && (rs_i == rd_i)) begin
      rdata_o = wdata_i;
`endif
    end else begin
      rdata_o = regs_i[rs_i];
    end
  end

endmodule

// File: rtl/reg_file.sv
// RV32I register file: 31 physical registers (x0 is constant zero), two async read ports, one write port.
// Optional build macro: REG_FILE_WRITE_BYPASS_EN (same-cycle write-through forwarding).
module reg_file
  import reg_file_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      reg_write,
  input  reg_data_t write_data,
  input  reg_addr_t rs1,
  input  reg_addr_t rs2,
  input  reg_addr_t rd,
  output reg_data_t out1,
  output reg_data_t out2
);

  reg_data_t                 regs_q [1:NREGS-1];
  reg_data_t                 regs_d [1:NREGS-1];
  logic [NREGS-1:0][XLEN-1:0] regs_s;

  // Per-register write decode; an unknown rd or reg_write fails the compare and leaves state alone.
  always_comb begin
    for (int i = 1; i < NREGS; i++) begin
      if (reg_write && (rd == AW'(i))) begin
        regs_d[i] = write_data;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Register storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) begin
        regs_q[i] <= DATA_ZERO;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Flat read view with x0 tied to zero.
  always_comb begin
    regs_s[0] = DATA_ZERO;
    for (int i = 1; i < NREGS; i++) begin
      regs_s[i] = regs_q[i];
    end
  end

`ifdef REG_FILE_WRITE_BYPASS_EN
  logic bypass_we_s;
  // Forwarding is suppressed during reset so the outputs stay at zero.
  assign bypass_we_s = reg_write && rst_n;
`endif

  reg_file_rd_port u_rd_port1 (
    .regs_i  (regs_s),
    .rs_i    (rs1),
`ifdef REG_FILE_WRITE_BYPASS_EN
    .we_i    (bypass_we_s),
    .rd_i    (rd),
    .wdata_i (write_data),
`endif
    .rdata_o (out1)
  );

  reg_file_rd_port u_rd_port2 (
    .regs_i  (regs_s),
    .rs_i    (rs2),
`ifdef REG_FILE_WRITE_BYPASS_EN
    .we_i    (bypass_we_s),
    .rd_i    (rd),
    .wdata_i (write_data),
`endif
    .rdata_o (out2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file (default build and REG_FILE_WRITE_BYPASS_EN build).
module tb_reg_file;
  import reg_file_pkg::*;

  logic      clk;
  logic      rst_n;
  logic      reg_write;
  reg_data_t write_data;
  reg_addr_t rs1;
  reg_addr_t rs2;
  reg_addr_t rd;
  reg_data_t out1;
  reg_data_t out2;

  int checks_cnt;
  int errors_cnt;

  reg_file dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .reg_write  (reg_write),
    .write_data (write_data),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .out1       (out1),
    .out2       (out2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input reg_data_t observed, input reg_data_t expected);
    checks_cnt++;
    assert (observed === expected)
    else begin
      errors_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic write_reg(input reg_addr_t addr, input reg_data_t data);
    reg_write  = 1'b1;
    rd         = addr;
    write_data = data;
    tick();
    reg_write  = 1'b0;
  endtask

  initial begin
    reg_data_t e1;
    reg_data_t e2;
    checks_cnt = 0;
    errors_cnt = 0;
    rst_n      = 1'b0;
    reg_write  = 1'b0;
    write_data = 32'h0000_0000;
    rs1        = 5'd1;
    rs2        = 5'd2;
    rd         = 5'd0;

    // Reset held for two edges, then released.
    tick();
    check("reset_out1", out1, 32'h0000_0000);
    check("reset_out2", out2, 32'h0000_0000);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_out1", out1, 32'h0000_0000);
    check("post_reset_out2", out2, 32'h0000_0000);

    // Basic write then read.
    write_reg(5'd3, 32'h0000_0007);
    rs1 = 5'd3;
    rs2 = 5'd4;
    #1;
    check("wr_rd_out1", out1, 32'h0000_0007);
    check("wr_rd_out2", out2, 32'h0000_0000);

    // x0 ignores writes.
    write_reg(5'd0, 32'hDEAD_BEEF);
    rs1 = 5'd0;
    rs2 = 5'd3;
    #1;
    check("x0_out1", out1, 32'h0000_0000);
    check("x0_keep_r3", out2, 32'h0000_0007);

    // Full sweep and dual-port reads.
    for (int i = 1; i < 32; i++) begin
      write_reg(5'(i), 32'(i) * 32'h0101_0101);
    end
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i);
      rs2 = 5'(31 - i);
      e1  = 32'(i) * 32'h0101_0101;
      e2  = 32'(31 - i) * 32'h0101_0101;
      #1;
      check($sformatf("sweep_out1_r%0d", i), out1, e1);
      check($sformatf("sweep_out2_r%0d", 31 - i), out2, e2);
    end

    // Same-register reads on both ports.
    rs1 = 5'd17;
    rs2 = 5'd17;
    #1;
    check("same_addr_out1", out1, 32'h1111_1111);
    check("same_addr_out2", out2, 32'h1111_1111);

    // Read/write collision on x5.
    write_reg(5'd5, 32'h0000_0007);
    reg_write  = 1'b1;
    rd         = 5'd5;
    write_data = 32'h0000_0009;
    rs1        = 5'd5;
    rs2        = 5'd6;
    #1;
`ifdef REG_FILE_WRITE_BYPASS_EN
    check("collide_before_out1", out1, 32'h0000_0009);
`else
    check("collide_before_out1", out1, 32'h0000_0007);
`endif
    check("collide_before_out2", out2, 32'h0606_0606);
    tick();
    reg_write = 1'b0;
    #1;
    check("collide_after_out1", out1, 32'h0000_0009);

    // Last write wins.
    write_reg(5'd9, 32'h1234_5678);
    write_reg(5'd9, 32'h8765_4321);
    rs1 = 5'd9;
    #1;
    check("last_write_wins", out1, 32'h8765_4321);

    // Asynchronous reset between edges with a concurrent write.
    write_reg(5'd3, 32'h0000_0007);
    rs1 = 5'd3;
    rs2 = 5'd6;
    #1;
    check("pre_async_out1", out1, 32'h0000_0007);
    reg_write  = 1'b1;
    rd         = 5'd3;
    write_data = 32'h0000_0055;
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_out1", out1, 32'h0000_0000);
    check("async_rst_out2", out2, 32'h0000_0000);
    tick();
    check("rst_blocks_write", out1, 32'h0000_0000);
    reg_write = 1'b0;
    rst_n     = 1'b1;
    tick();
    check("after_rst_r3", out1, 32'h0000_0000);
    check("after_rst_r6", out2, 32'h0000_0000);

    // Writes work again after reset.
    write_reg(5'd31, 32'hA5A5_A5A5);
    rs2 = 5'd31;
    #1;
    check("post_rst_write", out2, 32'hA5A5_A5A5);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
